// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the dense-layer forward and backward passes:
// default widths, value/accumulator types, the pass FSM states and a counter-width helper.
package nn_fixed_pkg;

    localparam int DW_DEF   = 18;
    localparam int AW_DEF   = 36;
    localparam int FRAC_DEF = 15;

    typedef logic signed [DW_DEF-1:0] fix_t;
    typedef logic signed [AW_DEF-1:0] acc_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fx_requant.sv
// Requantise an accumulator back to a fixed-point value: arithmetic shift right by
// FRAC (floor), then either wrap to DW bits or, with LAYER_BACKWARD_SAT_EN defined,
// clamp to the signed DW-bit range. Purely combinational so latency never changes.
module fx_requant
    import nn_fixed_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic signed [AW-1:0] acc,
    output logic signed [DW-1:0] q
);

    logic signed [AW-1:0] sh_s;

    assign sh_s = acc >>> FRAC;

`ifdef LAYER_BACKWARD_SAT_EN
    logic fits_s;

    // Value fits when every bit above the DW-bit sign position matches the sign.
    assign fits_s = (sh_s[AW-1:DW-1] == {(AW-DW+1){sh_s[AW-1]}});

    // Clamp out-of-range values toward the nearest representable extreme.
    always_comb begin
        q = sh_s[DW-1:0];
        if (fits_s) begin
            q = sh_s[DW-1:0];
        end else if (sh_s[AW-1]) begin
            q = {1'b1, {(DW-1){1'b0}}};
        end else begin
            q = {1'b0, {(DW-1){1'b1}}};
        end
    end
`else
    // Plain two's-complement wrap: keep the low DW bits.
    always_comb begin
        q = sh_s[DW-1:0];
    end
`endif

endmodule

// File: rtl/layer_backward.sv
// Backward (transpose) pass of the fixed-point dense layer:
//   dx[j] = requant( sum_i W[i*NIN+j] * dy[i] ), one MAC per clock.
// Runs once after reset release; done stays high until the next reset.
// Optional LAYER_BACKWARD_SAT_EN selects saturating requantisation in fx_requant.
module layer_backward
    import nn_fixed_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int NIN  = 2,
    parameter int NOUT = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] dy [0:NOUT-1],
    input  logic signed [DW-1:0] W  [0:NIN*NOUT-1],
    output logic signed [DW-1:0] dx [0:NIN-1],
    output logic                 done
);

    localparam int IW  = cnt_w(NOUT);
    localparam int JW  = cnt_w(NIN);
    localparam int WIW = cnt_w(NIN*NOUT);

    state_t                state;
    logic [IW-1:0]         i;
    logic [JW-1:0]         j;
    logic signed [AW-1:0]  acc;

    logic [WIW-1:0]         widx_s;
    logic signed [2*DW-1:0] prod_s;
    logic signed [AW-1:0]   acc_next_s;
    logic signed [DW-1:0]   q_s;

    // Weight address for the current (i, j) pair and the full-precision MAC result.
    always_comb begin
        widx_s     = WIW'(int'(i) * NIN + int'(j));
        prod_s     = W[widx_s] * dy[i];
        acc_next_s = acc + AW'(prod_s);
    end

    fx_requant #(
        .DW   (DW),
        .AW   (AW),
        .FRAC (FRAC)
    ) u_requant (
        .acc (acc),
        .q   (q_s)
    );

    // Pass sequencer: NOUT MAC cycles then one write cycle per dx element.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            i     <= '0;
            j     <= '0;
            acc   <= '0;
            done  <= 1'b0;
            for (int k = 0; k < NIN; k++) begin
                dx[k] <= '0;
            end
        end else begin
            case (state)
                RUN: begin
                    acc <= acc_next_s;
                    if (i == IW'(NOUT-1)) begin
                        state <= WRITE;
                    end else begin
                        i <= i + IW'(1);
                    end
                end
                WRITE: begin
                    dx[j] <= q_s;
                    acc   <= '0;
                    i     <= '0;
                    if (j == JW'(NIN-1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        j     <= j + JW'(1);
                        state <= RUN;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_backward.sv
// Self-checking bench for layer_backward: directed cases, mid-pass reset, randomized
// passes against a plain-arithmetic reference model, and a NIN=3/NOUT=1 instance.
module tb_layer_backward;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset6 = 1'b1;

    logic signed [17:0] dy  [0:19];
    logic signed [17:0] W   [0:39];
    logic signed [17:0] dx  [0:1];
    logic               done;

    logic signed [17:0] dy6 [0:0];
    logic signed [17:0] W6  [0:2];
    logic signed [17:0] dx6 [0:2];
    logic               done6;

    int m_w  [0:63];
    int m_dy [0:31];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer_backward u_dut (
        .clk   (clk),
        .reset (reset),
        .dy    (dy),
        .W     (W),
        .dx    (dx),
        .done  (done)
    );

    layer_backward #(.NIN(3), .NOUT(1)) u_dut6 (
        .clk   (clk),
        .reset (reset6),
        .dy    (dy6),
        .W     (W6),
        .dx    (dx6),
        .done  (done6)
    );

    // Reference: exact sum, wrap to 36 bits, floor-shift by 15, then wrap or clamp to 18 bits.
    function automatic longint model_dx(input int nin, input int nout, input int j);
        longint s;
        longint span;
        s = 0;
        for (int i = 0; i < nout; i++) begin
            s += longint'(m_w[i*nin+j]) * longint'(m_dy[i]);
        end
        span = longint'(1) <<< 36;
        s = s % span;
        if (s < 0) s += span;
        if (s >= span / 2) s -= span;
        s = s >>> 15;
`ifdef LAYER_BACKWARD_SAT_EN
        if (s > 131071) s = 131071;
        else if (s < -131072) s = -131072;
`else
        s = s % 262144;
        if (s < 0) s += 262144;
        if (s >= 131072) s -= 262144;
`endif
        return s;
    endfunction

    task automatic clear_stim();
        for (int k = 0; k < 64; k++) m_w[k] = 0;
        for (int k = 0; k < 32; k++) m_dy[k] = 0;
    endtask

    task automatic load_main();
        for (int k = 0; k < 20; k++) dy[k] = 18'(m_dy[k]);
        for (int k = 0; k < 40; k++) W[k] = 18'(m_w[k]);
    endtask

    task automatic load_six();
        dy6[0] = 18'(m_dy[0]);
        for (int k = 0; k < 3; k++) W6[k] = 18'(m_w[k]);
    endtask

    // Release the selected reset between edges and count edges until done, bounded.
    task automatic run_pass(input bit six, output int edges);
        edges = 0;
        @(negedge clk);
        if (six) reset6 = 1'b0;
        else     reset  = 1'b0;
        while (edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if ((six ? done6 : done) === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_stim();
        load_main();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (dx[j] !== 18'sd0) begin errors++; $display("FAIL reset_dx[%0d]: got %0d expected 0", j, dx[j]); end
        end
    endtask

    task automatic test_basic();
        int edges;
        logic signed [17:0] expv [0:1];
        reset = 1'b1;
        clear_stim();
        for (int i = 0; i < 20; i++) begin
            m_w[2*i]   = 16384;
            m_w[2*i+1] = -32768;
        end
        m_dy[0] = 32768;
        load_main();
        expv[0] = 18'sd16384;
        expv[1] = -18'sd32768;
        run_pass(1'b0, edges);
        checks++;
        if (edges != 42) begin errors++; $display("FAIL basic_latency: got %0d expected 42", edges); end
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (dx[j] !== expv[j]) begin errors++; $display("FAIL basic_dx[%0d]: got %0d expected %0d", j, dx[j], expv[j]); end
        end
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL basic_done_hold: got %b expected 1", done); end
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (dx[j] !== expv[j]) begin errors++; $display("FAIL basic_dx_hold[%0d]: got %0d expected %0d", j, dx[j], expv[j]); end
        end
    endtask

    task automatic test_async_clear();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL async_done: got %b expected 0", done); end
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (dx[j] !== 18'sd0) begin errors++; $display("FAIL async_dx[%0d]: got %0d expected 0", j, dx[j]); end
        end
    endtask

    task automatic test_directed(input string name, input int exp0, input int exp1);
        int edges;
        reset = 1'b1;
        load_main();
        run_pass(1'b0, edges);
        checks++;
        if (edges != 42) begin errors++; $display("FAIL %s_latency: got %0d expected 42", name, edges); end
        checks++;
        if (dx[0] !== 18'(exp0)) begin errors++; $display("FAIL %s_dx[0]: got %0d expected %0d", name, dx[0], exp0); end
        checks++;
        if (dx[1] !== 18'(exp1)) begin errors++; $display("FAIL %s_dx[1]: got %0d expected %0d", name, dx[1], exp1); end
    endtask

    task automatic test_midpass_reset();
        int edges;
        reset = 1'b1;
        clear_stim();
        m_w[6] = 1815;
        m_w[7] = 45889;
        m_dy[3] = 32768;
        load_main();
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (dx[j] !== 18'sd0) begin errors++; $display("FAIL midrst_dx[%0d]: got %0d expected 0", j, dx[j]); end
        end
        run_pass(1'b0, edges);
        checks++;
        if (edges != 42) begin errors++; $display("FAIL midrst_latency: got %0d expected 42", edges); end
        checks++;
        if (dx[0] !== 18'sd1815) begin errors++; $display("FAIL midrst_dx0: got %0d expected 1815", dx[0]); end
        checks++;
        if (dx[1] !== 18'sd45889) begin errors++; $display("FAIL midrst_dx1: got %0d expected 45889", dx[1]); end
    endtask

    task automatic test_random();
        int edges;
        longint expv;
        for (int r = 0; r < 5; r++) begin
            reset = 1'b1;
            clear_stim();
            for (int k = 0; k < 40; k++) m_w[k] = int'($urandom_range(262143)) - 131072;
            for (int k = 0; k < 20; k++) begin
                if (r == 0) m_dy[k] = int'($urandom_range(65535)) - 32768;
                else        m_dy[k] = int'($urandom_range(262143)) - 131072;
            end
            load_main();
            run_pass(1'b0, edges);
            checks++;
            if (edges != 42) begin errors++; $display("FAIL rand%0d_latency: got %0d expected 42", r, edges); end
            for (int j = 0; j < 2; j++) begin
                expv = model_dx(2, 20, j);
                checks++;
                if (dx[j] !== 18'(expv)) begin
                    errors++;
                    $display("FAIL rand%0d_dx[%0d]: got %0d expected %0d", r, j, dx[j], expv);
                end
            end
        end
    endtask

    task automatic test_small_params();
        int edges;
        int expv [0:2];
        reset6 = 1'b1;
        clear_stim();
        m_w[0] = 32768;
        m_w[1] = 16384;
        m_w[2] = -16384;
        m_dy[0] = 65536;
        load_six();
        expv[0] = 65536;
        expv[1] = 32768;
        expv[2] = -32768;
        run_pass(1'b1, edges);
        checks++;
        if (edges != 6) begin errors++; $display("FAIL small_latency: got %0d expected 6", edges); end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (dx6[j] !== 18'(expv[j])) begin errors++; $display("FAIL small_dx[%0d]: got %0d expected %0d", j, dx6[j], expv[j]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_async_clear();

        clear_stim();
        m_w[6] = 1815;
        m_w[7] = 45889;
        m_dy[3] = 32768;
        test_directed("layer5", 1815, 45889);

        clear_stim();
        m_w[0] = -1;
        m_dy[0] = 1;
        test_directed("negtrunc", -1, 0);

        clear_stim();
        for (int k = 0; k < 40; k++) m_w[k] = 32768;
        for (int k = 0; k < 20; k++) m_dy[k] = 32768;
`ifdef LAYER_BACKWARD_SAT_EN
        test_directed("overflow", 131071, 131071);
`else
        test_directed("overflow", -131072, -131072);
`endif

        test_midpass_reset();
        test_random();
        test_small_params();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
